// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from an external VGA sync pair sampled on a pixel strobe.
// Measures line and frame lengths and locks after two identical frames; all outputs are registered.
module vga_sync_decoder #(
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int CNT_MAX  = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_clk,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        draw_active,
   output logic        locked,
   output logic [11:0] line_len,
   output logic [11:0] frame_lines,
   output logic        frame_start,
   output logic        sync_err
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam logic [11:0] C_MAX = 12'(CNT_MAX);
   localparam logic [11:0] X_LO  = 12'(H_BP);
   localparam logic [11:0] X_HI  = 12'(H_BP + H_ACTIVE);
   localparam logic [11:0] Y_LO  = 12'(V_BP);
   localparam logic [11:0] Y_HI  = 12'(V_BP + V_ACTIVE);

   logic [1:0]  state_q, state_d;
   logic        hs_q, hs_d, vs_q, vs_d;
   logic        seen_v_q, seen_v_d, y_pend_q, y_pend_d;
   logic [11:0] h_cnt_q, h_cnt_d, x_cnt_q, x_cnt_d;
   logic [11:0] l_cnt_q, l_cnt_d, y_cnt_q, y_cnt_d;
   logic [11:0] ref_len_q, ref_len_d, ref_lines_q, ref_lines_d;
   logic [11:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        draw_q, draw_d, locked_q, locked_d;
   logic        frame_start_q, frame_start_d, sync_err_q, sync_err_d;

   logic        h_fall, h_rise, v_fall, v_rise, sat, err, x_act, y_act;
   logic [1:0]  st;
   logic [11:0] l_next;

   always_comb begin
      hs_d          = hs_q;
      vs_d          = vs_q;
      seen_v_d      = seen_v_q;
      y_pend_d      = y_pend_q;
      h_cnt_d       = h_cnt_q;
      x_cnt_d       = x_cnt_q;
      l_cnt_d       = l_cnt_q;
      y_cnt_d       = y_cnt_q;
      ref_len_d     = ref_len_q;
      ref_lines_d   = ref_lines_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      draw_d        = draw_q;
      locked_d      = locked_q;
      frame_start_d = 1'b0;
      sync_err_d    = 1'b0;
      h_fall        = pix_clk & hs_q & ~h_sync_in;
      h_rise        = pix_clk & ~hs_q & h_sync_in;
      v_fall        = pix_clk & vs_q & ~v_sync_in;
      v_rise        = pix_clk & ~vs_q & v_sync_in;
      sat           = 1'b0;
      err           = 1'b0;
      st            = state_q;
      l_next        = l_cnt_q;
      x_act         = 1'b0;
      y_act         = 1'b0;
      state_d       = state_q;

      if (pix_clk) begin
         hs_d = h_sync_in;
         vs_d = v_sync_in;

         // A line that ran into saturation reports CNT_MAX rather than wrapping.
         if (h_fall) begin
            line_len_d = (h_cnt_q == C_MAX) ? C_MAX : h_cnt_q + 12'd1;
            h_cnt_d    = '0;
         end else if (h_cnt_q != C_MAX) begin
            h_cnt_d = h_cnt_q + 12'd1;
            if (h_cnt_q == C_MAX - 12'd1) sat = 1'b1;
         end

         if (h_rise)                x_cnt_d = '0;
         else if (x_cnt_q != C_MAX) x_cnt_d = x_cnt_q + 12'd1;

         if (h_fall && l_cnt_q != C_MAX) begin
            l_next = l_cnt_q + 12'd1;
            if (!v_fall && l_cnt_q == C_MAX - 12'd1) sat = 1'b1;
         end
         if (v_fall) begin
            if (seen_v_q) frame_lines_d = l_next;
            seen_v_d = 1'b1;
            l_cnt_d  = '0;
         end else begin
            l_cnt_d = l_next;
         end

         if (v_rise) y_pend_d = 1'b1;
         if (h_fall) begin
            y_pend_d = 1'b0;
            if (y_pend_q | v_rise)     y_cnt_d = '0;
            else if (y_cnt_q != C_MAX) y_cnt_d = y_cnt_q + 12'd1;
         end

         // Line edge is resolved before the frame edge so a coincident h fall closes the frame.
         if (h_fall) begin
            case (st)
               ST_MEASURE: if (line_len_d != ref_len_q) ref_len_d = line_len_d;
               ST_LOCKED:  if (line_len_d != ref_len_q) begin st = ST_SEARCH; err = 1'b1; end
               default: ;
            endcase
         end
         if (v_fall) begin
            case (st)
               ST_SEARCH: begin
                  st          = ST_MEASURE;
                  ref_len_d   = line_len_d;
                  ref_lines_d = '0;
               end
               ST_MEASURE: begin
                  if (frame_lines_d == ref_lines_q && frame_lines_d != '0) st = ST_LOCKED;
                  else ref_lines_d = frame_lines_d;
               end
               ST_LOCKED: if (frame_lines_d != ref_lines_q) begin st = ST_SEARCH; err = 1'b1; end
               default: ;
            endcase
         end
         if (sat) begin
            st  = ST_SEARCH;
            err = 1'b1;
         end

         state_d       = st;
         sync_err_d    = err;
         frame_start_d = v_fall;
         x_act         = (x_cnt_d >= X_LO) && (x_cnt_d < X_HI);
         y_act         = (y_cnt_d >= Y_LO) && (y_cnt_d < Y_HI);
         locked_d      = (st == ST_LOCKED);
         draw_d        = locked_d & x_act & y_act;
         pix_x_d       = draw_d ? 10'(x_cnt_d - X_LO) : '0;
         pix_y_d       = draw_d ? 10'(y_cnt_d - Y_LO) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_SEARCH;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         seen_v_q      <= 1'b0;
         y_pend_q      <= 1'b0;
         h_cnt_q       <= '0;
         x_cnt_q       <= '0;
         l_cnt_q       <= '0;
         y_cnt_q       <= '0;
         ref_len_q     <= '0;
         ref_lines_q   <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         draw_q        <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         seen_v_q      <= seen_v_d;
         y_pend_q      <= y_pend_d;
         h_cnt_q       <= h_cnt_d;
         x_cnt_q       <= x_cnt_d;
         l_cnt_q       <= l_cnt_d;
         y_cnt_q       <= y_cnt_d;
         ref_len_q     <= ref_len_d;
         ref_lines_q   <= ref_lines_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         draw_q        <= draw_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign draw_active = draw_q;
   assign locked      = locked_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign frame_start = frame_start_q;
   assign sync_err    = sync_err_q;

endmodule
